// File: rtl/uart_rx_core_pkg.sv
// Shared UART types: receiver state encoding, per-frame configuration and the
// majority-vote helper used by the bit sampler.
package uart_rx_core_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } uart_rx_state_t;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic stop2;
  } uart_frame_cfg_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Push interface between the UART receiver and the upstream FIFO.
interface uart_rx_core_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  ufifo_full_i;
  logic                  ufifo_wr_o;
  logic [DATA_WIDTH-1:0] ufifo_wdata_o;

  modport master (input ufifo_full_i, output ufifo_wr_o, output ufifo_wdata_o);
  modport slave  (output ufifo_full_i, input ufifo_wr_o, input ufifo_wdata_o);
endinterface

// File: rtl/uart_rx_core_baud_tick.sv
// Sample-tick prescaler: one tick every max(div_i,1) clocks, restartable via clear_i.
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, last_s;

  // Next count and tick; a zero divider behaves like a divider of one.
  always_comb begin
    last_s = (div_i == {DIV_WIDTH{1'b0}}) ? {DIV_WIDTH{1'b0}} : div_i - DIV_WIDTH'(1);
    tick_o = 1'b0;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = {DIV_WIDTH{1'b0}};
    end else if (cnt_q >= last_s) begin
      tick_o = 1'b1;
      cnt_d  = {DIV_WIDTH{1'b0}};
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= {DIV_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises rx_i, majority-votes three mid-bit samples per bit
// and pushes each good byte into the upstream FIFO with registered strobes.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 stop2_i,
  uart_rx_core_if.master       ufifo,
  output logic                 rx_done_o,
  output logic                 parity_err_o,
  output logic                 bad_frame_o,
  output logic                 overflow_o,
  output logic                 rx_busy_o
);
  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] VOTE_A    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] VOTE_B    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] VOTE_C    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  uart_rx_state_t        state_q, state_d;
  uart_frame_cfg_t       cfg_q, cfg_d;
  logic [2:0]            sync_q;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]            vote_q, vote_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, wdata_q;
  logic                  perr_q, perr_d;
  logic                  wr_q, done_q, perr_out_q, bad_q, ovf_q;
  logic                  rx_s, fall_s, tick_s, clear_s, mid_s, end_s, vote_s;
  logic                  fin_ok_s, fin_bad_s;

  assign rx_s    = sync_q[1];
  assign fall_s  = sync_q[2] & ~sync_q[1];
  assign clear_s = (state_q == ST_IDLE) | ~en_i;
  assign mid_s   = tick_s & (tick_cnt_q == VOTE_C);
  assign end_s   = tick_s & (tick_cnt_q == LAST_TICK);
  assign vote_s  = majority3(vote_q[0], vote_q[1], rx_s);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (clear_s),
    .div_i   (baud_div_i),
    .tick_o  (tick_s)
  );

  // Next state, sampling counters and frame-completion decisions.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    fin_ok_s   = 1'b0;
    fin_bad_s  = 1'b0;
    if (!en_i) begin
      state_d    = ST_IDLE;
      tick_cnt_d = {CW{1'b0}};
      bit_cnt_d  = {BW{1'b0}};
      perr_d     = 1'b0;
    end else begin
      if (tick_s) begin
        tick_cnt_d = (tick_cnt_q == LAST_TICK) ? {CW{1'b0}} : tick_cnt_q + CW'(1);
        if (tick_cnt_q == VOTE_A) begin
          vote_d[0] = rx_s;
        end else if (tick_cnt_q == VOTE_B) begin
          vote_d[1] = rx_s;
        end else begin
          vote_d = vote_q;
        end
      end else begin
        tick_cnt_d = tick_cnt_q;
      end
      case (state_q)
        ST_IDLE: begin
          tick_cnt_d = {CW{1'b0}};
          bit_cnt_d  = {BW{1'b0}};
          perr_d     = 1'b0;
          if (fall_s) begin
            state_d = ST_START;
            cfg_d   = '{parity_en: parity_en_i, parity_odd: parity_odd_i, stop2: stop2_i};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_s && vote_s) begin
            state_d = ST_IDLE;
          end else if (end_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (mid_s) begin
            shift_d = {vote_s, shift_q[DATA_WIDTH-1:1]};
          end else begin
            shift_d = shift_q;
          end
          if (end_s) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP1;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          // A mismatch is vote != (^data ^ odd); the flag lives until IDLE.
          if (mid_s) begin
            perr_d = vote_s ^ (^shift_q) ^ cfg_q.parity_odd;
          end else begin
            perr_d = perr_q;
          end
          if (end_s) begin
            state_d = ST_STOP1;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP1: begin
          if (mid_s) begin
            if (!vote_s) begin
              fin_bad_s = 1'b1;
              state_d   = ST_WAIT_HIGH;
            end else if (!cfg_q.stop2) begin
              fin_ok_s = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_STOP1;
            end
          end else if (end_s) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_STOP1;
          end
        end
        ST_STOP2: begin
          if (mid_s) begin
            fin_ok_s  = vote_s;
            fin_bad_s = ~vote_s;
            state_d   = vote_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            state_d = ST_STOP2;
          end
        end
        ST_WAIT_HIGH: begin
          state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Line synchroniser plus edge-detect flop, all idling high.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '{parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
      tick_cnt_q <= {CW{1'b0}};
      bit_cnt_q  <= {BW{1'b0}};
      vote_q     <= 2'b11;
      shift_q    <= {DATA_WIDTH{1'b0}};
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      vote_q     <= vote_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
    end
  end

  // Registered strobes; a bad frame suppresses push, done and overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
      perr_out_q <= 1'b0;
      wdata_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_q       <= fin_ok_s & ~ufifo.ufifo_full_i;
      done_q     <= fin_ok_s & ~ufifo.ufifo_full_i;
      ovf_q      <= fin_ok_s & ufifo.ufifo_full_i;
      bad_q      <= fin_bad_s;
      perr_out_q <= (fin_ok_s | fin_bad_s) & perr_q;
      if (fin_ok_s && !ufifo.ufifo_full_i) begin
        wdata_q <= shift_q;
      end
    end
  end

  assign ufifo.ufifo_wr_o    = wr_q;
  assign ufifo.ufifo_wdata_o = wdata_q;
  assign rx_done_o           = done_q;
  assign parity_err_o        = perr_out_q;
  assign bad_frame_o         = bad_q;
  assign overflow_o          = ovf_q;
  assign rx_busy_o           = (state_q != ST_IDLE);
endmodule
